// File: rtl/cpu_4bit_core.sv
// rtl/cpu_4bit_core.sv - single-cycle 4-bit core: 4x4b regs, Z flag, 16x4 DMEM, 4b PC
// Optional debug ports under CPU_4BIT_DEBUG_EN.
module cpu_4bit_core (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  instr_data,
  output logic [3:0]  instr_addr
`ifdef CPU_4BIT_DEBUG_EN
  ,
  output logic [15:0] dbg_regs,
  output logic        dbg_z
`endif
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_MOVI = 4'h1, OP_MOV  = 4'h2, OP_ADD  = 4'h3,
    OP_SUB  = 4'h4, OP_ADDI = 4'h5, OP_SUBI = 4'h6, OP_LSLI = 4'h7,
    OP_LSRI = 4'h8, OP_AND  = 4'h9, OP_OR   = 4'hA, OP_LD   = 4'hB,
    OP_ST   = 4'hC, OP_B    = 4'hD, OP_BEQ  = 4'hE, OP_BNE  = 4'hF
  } opcode_e;

  logic [3:0] rf_q   [4];
  logic [3:0] dmem_q [16];
  logic [3:0] pc_q;
  logic       z_q;

  opcode_e    opcode;
  logic [1:0] val2;
  logic [1:0] src;
  logic [1:0] dst;
  logic [3:0] rd_val;
  logic [3:0] rs_val;
  logic [3:0] res_d;
  logic [3:0] pc_d;
  logic       rf_we;
  logic       z_we;
  logic       dm_we;

  assign instr_addr = pc_q;

  always_comb begin
    opcode = opcode_e'(instr_data[7:4]);
    val2   = instr_data[3:2];
    src    = instr_data[3:2];
    dst    = instr_data[1:0];
    rd_val = rf_q[dst];
    rs_val = rf_q[src];
    res_d  = rd_val;
    pc_d   = pc_q + 4'd1;
    rf_we  = 1'b0;
    z_we   = 1'b0;
    dm_we  = 1'b0;
    case (opcode)
      OP_NOP:  ;
      OP_MOVI: begin res_d = {2'b00, val2};            rf_we = 1'b1; end
      OP_MOV:  begin res_d = rs_val;                   rf_we = 1'b1; end
      OP_ADD:  begin res_d = rd_val + rs_val;          rf_we = 1'b1; z_we = 1'b1; end
      OP_SUB:  begin res_d = rd_val - rs_val;          rf_we = 1'b1; z_we = 1'b1; end
      OP_ADDI: begin res_d = rd_val + {2'b00, val2};   rf_we = 1'b1; z_we = 1'b1; end
      OP_SUBI: begin res_d = rd_val - {2'b00, val2};   rf_we = 1'b1; z_we = 1'b1; end
      OP_LSLI: begin res_d = rd_val << val2;           rf_we = 1'b1; z_we = 1'b1; end
      OP_LSRI: begin res_d = rd_val >> val2;           rf_we = 1'b1; z_we = 1'b1; end
      OP_AND:  begin res_d = rd_val & rs_val;          rf_we = 1'b1; z_we = 1'b1; end
      OP_OR:   begin res_d = rd_val | rs_val;          rf_we = 1'b1; z_we = 1'b1; end
      OP_LD:   begin res_d = dmem_q[rs_val];           rf_we = 1'b1; end
      OP_ST:   dm_we = 1'b1;
      OP_B:    pc_d = instr_data[3:0];
      OP_BEQ:  if (z_q)  pc_d = instr_data[3:0];
      OP_BNE:  if (!z_q) pc_d = instr_data[3:0];
      default: ;
    endcase
  end

  // DMEM is cleared by reset too, so it lives in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= 4'd0;
      z_q  <= 1'b0;
      for (int i = 0; i < 4; i++)  rf_q[i]   <= 4'd0;
      for (int i = 0; i < 16; i++) dmem_q[i] <= 4'd0;
    end else begin
      pc_q <= pc_d;
      if (z_we)  z_q <= (res_d == 4'd0);
      if (rf_we) rf_q[dst] <= res_d;
      if (dm_we) dmem_q[rd_val] <= rs_val;
    end
  end

`ifdef CPU_4BIT_DEBUG_EN
  assign dbg_regs = {rf_q[3], rf_q[2], rf_q[1], rf_q[0]};
  assign dbg_z    = z_q;
`endif

endmodule

// File: tb/tb_cpu_4bit_core.sv
// tb/tb_cpu_4bit_core.sv - self-checking bench for cpu_4bit_core with an ISA-level model
module tb_cpu_4bit_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  instr_data;
  logic [3:0]  instr_addr;
  logic [15:0] obs_regs;
  logic        obs_z;
  logic [7:0]  imem [16];

  int checks = 0;
  int errors = 0;

  int m_r [4];
  int m_mem [16];
  int m_z;
  int m_pc;

  always #5 clk = ~clk;

  assign instr_data = imem[instr_addr];

`ifdef CPU_4BIT_DEBUG_EN
  cpu_4bit_core dut (
    .clk(clk), .reset_n(reset_n), .instr_data(instr_data), .instr_addr(instr_addr),
    .dbg_regs(obs_regs), .dbg_z(obs_z)
  );
`else
  cpu_4bit_core dut (
    .clk(clk), .reset_n(reset_n), .instr_data(instr_data), .instr_addr(instr_addr)
  );
  assign obs_regs = {dut.rf_q[3], dut.rf_q[2], dut.rf_q[1], dut.rf_q[0]};
  assign obs_z    = dut.z_q;
`endif

  function automatic logic [15:0] model_regs();
    return 16'((m_r[3] << 12) | (m_r[2] << 8) | (m_r[1] << 4) | m_r[0]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++)  m_r[i] = 0;
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    m_z = 0;
    m_pc = 0;
  endtask

  // Interprets one instruction with integer arithmetic, mod 16 throughout.
  task automatic model_step();
    logic [7:0] ins;
    int op, a, d, t, res, nxt;
    bit upd_r, upd_z;
    ins = imem[m_pc];
    op = ins[7:4]; a = ins[3:2]; d = ins[1:0]; t = ins[3:0];
    nxt = (m_pc + 1) % 16;
    upd_r = 1; upd_z = 1; res = 0;
    case (op)
      0:  begin upd_r = 0; upd_z = 0; end
      1:  begin res = a; upd_z = 0; end
      2:  begin res = m_r[a]; upd_z = 0; end
      3:  res = (m_r[d] + m_r[a]) % 16;
      4:  res = (m_r[d] - m_r[a] + 16) % 16;
      5:  res = (m_r[d] + a) % 16;
      6:  res = (m_r[d] - a + 16) % 16;
      7:  res = (m_r[d] * (1 << a)) % 16;
      8:  res = m_r[d] / (1 << a);
      9:  res = m_r[d] & m_r[a];
      10: res = m_r[d] | m_r[a];
      11: begin res = m_mem[m_r[a]]; upd_z = 0; end
      12: begin m_mem[m_r[d]] = m_r[a]; upd_r = 0; upd_z = 0; end
      13: begin nxt = t; upd_r = 0; upd_z = 0; end
      14: begin if (m_z == 1) nxt = t; upd_r = 0; upd_z = 0; end
      default: begin if (m_z == 0) nxt = t; upd_r = 0; upd_z = 0; end
    endcase
    if (upd_z) m_z = (res == 0) ? 1 : 0;
    if (upd_r) m_r[d] = res;
    m_pc = nxt;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic start_program(input logic [7:0] prog [16]);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) imem[i] = prog[i];
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] prog [16];
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    for (int i = 0; i < 16; i++) imem[i] = 8'h1F;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (instr_addr !== 4'd0 || obs_regs !== 16'h0 || obs_z !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: pc=%0d regs=%h z=%b, required pc=0 regs=0000 z=0", instr_addr, obs_regs, obs_z);
    end
    start_program(prog);
    for (int i = 1; i <= 20; i++) begin
      step(1);
      checks++;
      if (instr_addr !== 4'(i % 16)) begin
        errors++;
        $display("FAIL nop_pc_step%0d: pc=%0d required %0d", i, instr_addr, i % 16);
      end
    end
  endtask

  task automatic test_imm_arith();
    logic [7:0] prog [16];
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'h1F; prog[1] = 8'h1E; prog[2] = 8'h7B; prog[3] = 8'h3B;
    start_program(prog);
    step(4);
    checks++;
    if (obs_regs[15:12] !== 4'd15 || obs_regs[11:8] !== 4'd3 || obs_z !== 1'b0 || instr_addr !== 4'd4) begin
      errors++;
      $display("FAIL imm_arith: R3=%0d R2=%0d z=%b pc=%0d, required R3=15 R2=3 z=0 pc=4",
               obs_regs[15:12], obs_regs[11:8], obs_z, instr_addr);
    end
  endtask

  task automatic load_countdown(output logic [7:0] prog [16]);
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'h1F; prog[1] = 8'h1E; prog[2] = 8'h7B; prog[3] = 8'h3B;
    prog[4] = 8'h10; prog[5] = 8'hCC; prog[6] = 8'h54; prog[7] = 8'h67;
    prog[8] = 8'hF5; prog[9] = 8'hE9;
  endtask

  task automatic test_countdown();
    logic [7:0] prog [16];
    load_countdown(prog);
    start_program(prog);
    step(65);
    checks++;
    if (instr_addr !== 4'd9 || obs_regs[15:12] !== 4'd0 || obs_regs[3:0] !== 4'd15 || obs_z !== 1'b1) begin
      errors++;
      $display("FAIL countdown_end: pc=%0d R3=%0d R0=%0d z=%b, required pc=9 R3=0 R0=15 z=1",
               instr_addr, obs_regs[15:12], obs_regs[3:0], obs_z);
    end
    step(5);
    checks++;
    if (instr_addr !== 4'd9) begin
      errors++;
      $display("FAIL countdown_halt: pc=%0d required 9", instr_addr);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dut.dmem_q[i] !== 4'((i == 15) ? 0 : 15 - i)) begin
        errors++;
        $display("FAIL countdown_dmem%0d: got %0d required %0d", i, dut.dmem_q[i], (i == 15) ? 0 : 15 - i);
      end
    end
  endtask

  task automatic test_ldst_logic();
    logic [7:0] prog [16];
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'h19; prog[1] = 8'h1E; prog[2] = 8'hC9; prog[3] = 8'hB4;
    prog[4] = 8'h94; prog[5] = 8'h44; prog[6] = 8'h2B;
    start_program(prog);
    step(4);
    checks++;
    if (obs_regs[3:0] !== 4'd3) begin
      errors++;
      $display("FAIL ld_after_st: R0=%0d required 3", obs_regs[3:0]);
    end
    step(1);
    checks++;
    if (obs_regs[3:0] !== 4'd2 || obs_z !== 1'b0) begin
      errors++;
      $display("FAIL and: R0=%0d z=%b required R0=2 z=0", obs_regs[3:0], obs_z);
    end
    step(1);
    checks++;
    if (obs_regs[3:0] !== 4'd0 || obs_z !== 1'b1) begin
      errors++;
      $display("FAIL sub_zero: R0=%0d z=%b required R0=0 z=1", obs_regs[3:0], obs_z);
    end
    step(1);
    checks++;
    if (obs_regs[15:12] !== 4'd3 || obs_z !== 1'b1) begin
      errors++;
      $display("FAIL mov_keeps_z: R3=%0d z=%b required R3=3 z=1", obs_regs[15:12], obs_z);
    end
  endtask

  task automatic test_wrap_branches();
    logic [7:0] prog [16];
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0] = 8'h1C; prog[1] = 8'h78; prog[2] = 8'h5C; prog[3] = 8'h54;
    prog[4] = 8'h64; prog[5] = 8'h19; prog[6] = 8'h79; prog[7] = 8'h8D;
    prog[8] = 8'hDC;
    start_program(prog);
    step(3);
    checks++;
    if (obs_regs[3:0] !== 4'd15) begin
      errors++;
      $display("FAIL build15: R0=%0d required 15", obs_regs[3:0]);
    end
    step(1);
    checks++;
    if (obs_regs[3:0] !== 4'd0 || obs_z !== 1'b1) begin
      errors++;
      $display("FAIL addi_wrap: R0=%0d z=%b required R0=0 z=1", obs_regs[3:0], obs_z);
    end
    step(1);
    checks++;
    if (obs_regs[3:0] !== 4'd15 || obs_z !== 1'b0) begin
      errors++;
      $display("FAIL subi_wrap: R0=%0d z=%b required R0=15 z=0", obs_regs[3:0], obs_z);
    end
    step(3);
    checks++;
    if (obs_regs[7:4] !== 4'd1) begin
      errors++;
      $display("FAIL lsri3: R1=%0d required 1", obs_regs[7:4]);
    end
    step(1);
    checks++;
    if (instr_addr !== 4'd12) begin
      errors++;
      $display("FAIL b12: pc=%0d required 12", instr_addr);
    end
  endtask

  task automatic test_random();
    logic [7:0] prog [16];
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
      start_program(prog);
      for (int c = 0; c < 40; c++) begin
        step(1);
        checks++;
        if (instr_addr !== 4'(m_pc) || obs_regs !== model_regs() || obs_z !== 1'(m_z)) begin
          errors++;
          $display("FAIL random_p%0d_c%0d: pc=%0d regs=%h z=%b, required pc=%0d regs=%h z=%0d",
                   p, c, instr_addr, obs_regs, obs_z, m_pc, model_regs(), m_z);
        end
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (dut.dmem_q[i] !== 4'(m_mem[i])) begin
          errors++;
          $display("FAIL random_p%0d_dmem%0d: got %0d required %0d", p, i, dut.dmem_q[i], m_mem[i]);
        end
      end
    end
  endtask

  task automatic test_midrun_reset();
    logic [7:0] prog [16];
    int nz;
    load_countdown(prog);
    start_program(prog);
    step(30);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    nz = 0;
    for (int i = 0; i < 16; i++) if (dut.dmem_q[i] !== 4'd0) nz++;
    checks++;
    if (instr_addr !== 4'd0 || obs_regs !== 16'h0 || obs_z !== 1'b0 || nz != 0) begin
      errors++;
      $display("FAIL midrun_clear: pc=%0d regs=%h z=%b nonzero_dmem=%0d, required all 0",
               instr_addr, obs_regs, obs_z, nz);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      checks++;
      if (instr_addr !== 4'(m_pc) || obs_regs !== model_regs() || obs_z !== 1'(m_z)) begin
        errors++;
        $display("FAIL restart_c%0d: pc=%0d regs=%h z=%b, required pc=%0d regs=%h z=%0d",
                 c, instr_addr, obs_regs, obs_z, m_pc, model_regs(), m_z);
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dut.dmem_q[i] !== 4'(m_mem[i])) begin
        errors++;
        $display("FAIL restart_dmem%0d: got %0d required %0d", i, dut.dmem_q[i], m_mem[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = 8'h00;
    model_reset();
    test_reset();
    test_imm_arith();
    test_countdown();
    test_ldst_logic();
    test_wrap_branches();
    test_random();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
